// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if -- memory-stage data-memory interface
//
// Sits after the M stage of the pipelined datapath. It turns the M-stage
// load/store strobes into transactions on a variable-latency req/ready memory
// port. While an access is outstanding it holds stallM high to freeze the
// F/D/E/M registers. Loads return readdataM in the cycle they complete.
//
// Optional feature, selected with the macro DMEM_STORE_BUFFER_EN:
//   defined   - stores are posted into an SBUF_DEPTH-entry FIFO and drained
//               in the background. Loads that hit a buffered word are
//               forwarded the youngest matching data with no stall.
//   undefined - no buffer. A store stalls the pipeline until its memory write
//               completes, the same way a load does.
//
// Parameters
//   SBUF_DEPTH  store-buffer entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   memreadM    M-stage load strobe (held while stallM=1)
//   memwriteM   M-stage store strobe (held while stallM=1)
//   aluoutM     byte address
//   writedataM  store data
//   readdataM   load data, valid when memreadM=1 and stallM=0, else 0
//   stallM      combinational pipeline freeze
//   misalign    combinational flag for a non-word-aligned access
//   mem_req     registered memory request
//   mem_we      registered write enable (1 = write)
//   mem_addr    registered word address
//   mem_wdata   registered write data
//   mem_ready   completes the current request when sampled high
//   mem_rdata   read data, valid while mem_ready=1 on a read
// -----------------------------------------------------------------------------
module dmem_if #(
  parameter int SBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [29:0] word_addr;

  assign word_addr = aluoutM[31:2];
  assign misalign  = (memreadM | memwriteM) & (aluoutM[1:0] != 2'b00);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMEM_STORE_BUFFER_EN
  // ---------------------------------------------------------------------------
  // Store buffer: circular FIFO of word address + data
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(SBUF_DEPTH);
  localparam int CW = AW + 1;

  logic [29:0]   sbuf_addr_q [SBUF_DEPTH];
  logic [31:0]   sbuf_data_q [SBUF_DEPTH];
  logic [AW-1:0] sbuf_head_q, sbuf_tail_q;
  logic [CW-1:0] sbuf_count_q;

  logic          sbuf_full;
  logic          sbuf_push;
  logic          sbuf_pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [AW-1:0] fwd_idx;

  // Full is taken from the registered count, so a store never slips in on
  // the same edge a drain pops. It is accepted the following cycle.
  assign sbuf_full = (sbuf_count_q == CW'(SBUF_DEPTH));
  // A store together with a load counts as a load, so it is never posted.
  assign sbuf_push = memwriteM & ~memreadM & ~stallM;
  assign sbuf_pop  = (state_q == DRAIN) & mem_ready;

  // Scan from oldest to youngest, so the last match is the youngest store.
  // The entry currently draining stays in the FIFO until its pop, so it is
  // also a forwarding source.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = sbuf_head_q;
    for (int i = 0; i < SBUF_DEPTH; i++) begin
      fwd_idx = sbuf_head_q + AW'(i);
      if ((CW'(i) < sbuf_count_q) && (sbuf_addr_q[fwd_idx] == word_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sbuf_data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sbuf_head_q  <= '0;
      sbuf_tail_q  <= '0;
      sbuf_count_q <= '0;
    end else begin
      if (sbuf_push) sbuf_tail_q <= sbuf_tail_q + AW'(1);
      if (sbuf_pop)  sbuf_head_q <= sbuf_head_q + AW'(1);
      case ({sbuf_push, sbuf_pop})
        2'b10:   sbuf_count_q <= sbuf_count_q + CW'(1);
        2'b01:   sbuf_count_q <= sbuf_count_q - CW'(1);
        default: sbuf_count_q <= sbuf_count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Entries are only ever read below
  // the count, and clearing the pointers empties the buffer.
  always_ff @(posedge clk) begin
    if (sbuf_push) begin
      sbuf_addr_q[sbuf_tail_q] <= word_addr;
      sbuf_data_q[sbuf_tail_q] <= writedataM;
    end
  end
`else
  // The depth only sizes the store buffer. Without the buffer it is a no-op.
  logic [31:0] unused_sbuf_depth;
  assign unused_sbuf_depth = 32'(SBUF_DEPTH);
`endif

  // ---------------------------------------------------------------------------
  // Control: stall/readdata outputs and next-state / request registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stallM      = 1'b0;
    readdataM   = '0;

    if (memreadM) begin
      if (state_q == LOAD) begin
        stallM = ~mem_ready;
        if (mem_ready) readdataM = mem_rdata;
      end
`ifdef DMEM_STORE_BUFFER_EN
      else if (fwd_hit) begin
        readdataM = fwd_data;
      end
`endif
      else begin
        stallM = 1'b1;
      end
    end else if (memwriteM) begin
`ifdef DMEM_STORE_BUFFER_EN
      stallM = sbuf_full;
`else
      stallM = (state_q == DRAIN) ? ~mem_ready : 1'b1;
`endif
    end

    case (state_q)
      IDLE: begin
`ifdef DMEM_STORE_BUFFER_EN
        // A pending load always beats a drain.
        if (memreadM && !fwd_hit) begin
          state_d     = LOAD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {word_addr, 2'b00};
          mem_wdata_d = '0;
        end else if (sbuf_count_q != '0) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {sbuf_addr_q[sbuf_head_q], 2'b00};
          mem_wdata_d = sbuf_data_q[sbuf_head_q];
        end
`else
        if (memreadM) begin
          state_d     = LOAD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {word_addr, 2'b00};
          mem_wdata_d = '0;
        end else if (memwriteM) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {word_addr, 2'b00};
          mem_wdata_d = writedataM;
        end
`endif
      end
      LOAD, DRAIN: begin
        // Only mem_req drops on completion. The other request fields hold
        // their values until the next transaction starts.
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_if.sv
// -----------------------------------------------------------------------------
// tb_dmem_if -- directed testbench for dmem_if
//
// Expected memory transactions are queued when stimulus is applied. The
// memory model pops and compares each one as the DUT raises mem_req. Then it
// answers after a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_dmem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, misalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_if #(.SBUF_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          mem_wait  = 0;
  logic [31:0] rdata_cfg = '0;
  bit          busy      = 1'b0;
  int          wcnt      = 0;

  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void expect_txn(input logic [31:0] addr, input logic we,
                                     input logic [31:0] wdata);
    txn_t t;
    t.addr  = {addr[31:2], 2'b00};
    t.we    = we;
    t.wdata = wdata;
    sb.push_back(t);
  endfunction

  // Advance one clock. Then update the memory model: retire a completed
  // request, score a newly raised one, and drive mem_ready after mem_wait
  // cycles.
  task automatic tick();
    txn_t t;
    @(posedge clk);
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      mem_rdata = JUNK;
      busy      = 1'b0;
    end
    if (mem_req && !busy) begin
      busy = 1'b1;
      wcnt = 0;
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL req_unexpected: observed request addr %h we %0d, expected none",
               mem_addr, mem_we);
      end
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("req_addr", mem_addr, t.addr);
        check("req_we", 32'(mem_we), 32'(t.we));
        if (t.we) check("req_wdata", mem_wdata, t.wdata);
      end
    end
    if (mem_req && busy) begin
      if (wcnt >= mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_cfg;
      end else begin
        wcnt++;
      end
    end
    #1;
  endtask

  // One memory-bound access: count stall cycles until the pipeline is
  // released, check the load data in the release cycle, then retire.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_cyc, input logic [31:0] rdata,
                           input int exp_stalls);
    int stalls;
    stalls    = 0;
    mem_wait  = wait_cyc;
    rdata_cfg = rdata;
    memreadM  = rd;
    memwriteM = wr;
    aluoutM   = addr;
    writedataM = wdata;
    expect_txn(addr, rd ? 1'b0 : 1'b1, wdata);
    #1;
    check({tag, "_misalign"}, 32'(misalign), 32'(addr[1:0] != 2'b00));
    while (stallM && stalls < 100) begin
      if (stalls == 0) check({tag, "_rdata_while_stalled"}, readdataM, 32'h0);
      stalls++;
      tick();
    end
    check({tag, "_stall_cycles"}, stalls, exp_stalls);
    if (rd) check({tag, "_rdata"}, readdataM, rdata);
    tick();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    #1;
  endtask

  // Idle the M stage until every queued transaction has been seen and
  // retired.
  task automatic drain_all(input string tag);
    int n;
    n = 0;
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    while ((sb.size() > 0 || mem_req) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_queue_left"}, sb.size(), 0);
    check({tag, "_req_idle"}, 32'(mem_req), 32'h0);
  endtask

  initial begin
    reset      = 1'b0;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    aluoutM    = '0;
    writedataM = '0;
    mem_ready  = 1'b0;
    mem_rdata  = JUNK;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stallM", 32'(stallM), 32'h0);
    check("rst_readdataM", readdataM, 32'h0);
    reset = 1'b1;
    tick();

    // No strobes: low address bits do not raise misalign
    aluoutM = 32'h0000_0003;
    #1;
    check("nostrobe_misalign", 32'(misalign), 32'h0);
    check("nostrobe_stall", 32'(stallM), 32'h0);
    check("nostrobe_rdata", readdataM, 32'h0);
    tick();

    // Load after 3 wait cycles -> 4 stall cycles
    do_access("ld100", 1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 4);
    // Ready in the first LOAD cycle -> exactly 1 stall cycle
    do_access("ld_min", 1'b1, 1'b0, 32'h104, 32'h0, 0, 32'h1234_5678, 1);
    // Load and store together behave as a load only
    do_access("ld_st_both", 1'b1, 1'b1, 32'h108, 32'hFFFF_0000, 1, 32'h0BAD_F00D, 2);

`ifdef DMEM_STORE_BUFFER_EN
    // Two stores to one word, then a forwarded load while memory is blocked
    mem_wait   = 1000;
    memwriteM  = 1'b1;
    aluoutM    = 32'h40;
    writedataM = 32'h11;
    expect_txn(32'h40, 1'b1, 32'h11);
    #1;
    check("fwd_st1_stall", 32'(stallM), 32'h0);
    tick();
    writedataM = 32'h22;
    expect_txn(32'h40, 1'b1, 32'h22);
    #1;
    check("fwd_st2_stall", 32'(stallM), 32'h0);
    tick();
    memwriteM = 1'b0;
    memreadM  = 1'b1;
    #1;
    check("fwd_ld_stall", 32'(stallM), 32'h0);
    check("fwd_ld_rdata", readdataM, 32'h22);
    tick();
    memreadM = 1'b0;
    mem_wait = 0;
    drain_all("fwd_drain");

    // Fill the buffer while memory is blocked; the fifth store waits
    mem_wait = 1000;
    for (int i = 0; i < 4; i++) begin
      memwriteM  = 1'b1;
      aluoutM    = 32'h80 + 32'(4 * i);
      writedataM = 32'h100 + 32'(i);
      expect_txn(aluoutM, 1'b1, writedataM);
      #1;
      check($sformatf("full_st%0d_stall", i), 32'(stallM), 32'h0);
      tick();
    end
    aluoutM    = 32'h90;
    writedataM = 32'h104;
    expect_txn(32'h90, 1'b1, 32'h104);
    #1;
    check("full_st4_stall", 32'(stallM), 32'h1);
    mem_wait = 0;
    tick();
    check("full_st4_ready_cycle", 32'(mem_ready), 32'h1);
    check("full_st4_stall_at_pop", 32'(stallM), 32'h1);
    tick();
    check("full_st4_accept", 32'(stallM), 32'h0);
    tick();
    drain_all("full_drain");

    // Misaligned load arriving during an outstanding drain
    mem_wait   = 2;
    memwriteM  = 1'b1;
    aluoutM    = 32'h300;
    writedataM = 32'h55;
    expect_txn(32'h300, 1'b1, 32'h55);
    #1;
    tick();
    memwriteM = 1'b0;
    tick();
    check("mis_drain_req", 32'(mem_req), 32'h1);
    do_access("mis_ld203", 1'b1, 1'b0, 32'h203, 32'h0, 2, 32'hCAFE_0203, 6);
`else
    // Unbuffered store: 1 IDLE stall + 2 wait cycles
    do_access("st40", 1'b0, 1'b1, 32'h40, 32'h11, 2, 32'h0, 3);
    // Misaligned store goes to the aligned word
    do_access("st_mis", 1'b0, 1'b1, 32'h0A, 32'h33, 0, 32'h0, 1);
    // Misaligned load goes to the aligned word
    do_access("mis_ld203", 1'b1, 1'b0, 32'h203, 32'h0, 2, 32'hCAFE_0203, 3);
`endif

    // Reset while a load is outstanding
    mem_wait = 1000;
`ifdef DMEM_STORE_BUFFER_EN
    memwriteM  = 1'b1;
    aluoutM    = 32'h400;
    writedataM = 32'h77;
    #1;
    tick();
    memwriteM = 1'b0;
`endif
    memreadM = 1'b1;
    aluoutM  = 32'h500;
    expect_txn(32'h500, 1'b0, 32'h0);
    #1;
    check("rstld_stall", 32'(stallM), 32'h1);
    tick();
    check("rstld_req", 32'(mem_req), 32'h1);
    reset    = 1'b0;
    memreadM = 1'b0;
    tick();
    busy = 1'b0;
    check("rstld_mem_req", 32'(mem_req), 32'h0);
    check("rstld_mem_we", 32'(mem_we), 32'h0);
    check("rstld_mem_addr", mem_addr, 32'h0);
    check("rstld_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    repeat (3) tick();
    check("rstld_no_drain", 32'(mem_req), 32'h0);
    do_access("post_rst_ld", 1'b1, 1'b0, 32'h504, 32'h0, 1, 32'h5EED_0504, 2);

    check("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
